// File: rtl/int_fp_mac_pkg.sv
// Shared definitions for the int_fp_add pattern checker: pattern word layout,
// checker state encoding and a field-unpacking helper.
package int_fp_mac_pkg;

    localparam int PAT_W    = 49;
    localparam int FIELD_W  = 16;
    localparam int IN1_MSB  = 48;
    localparam int IN2_MSB  = 32;
    localparam int EXP_MSB  = 16;
    localparam int MODE_BIT = 0;
    localparam int TIMER_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_APPLY = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } chk_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] in1;
        logic [FIELD_W-1:0] in2;
        logic [FIELD_W-1:0] expected;
        logic               mode;
    } pat_fields_t;

    function automatic pat_fields_t unpack_pat(input logic [PAT_W-1:0] w);
        pat_fields_t f;
        f.in1      = w[IN1_MSB -: FIELD_W];
        f.in2      = w[IN2_MSB -: FIELD_W];
        f.expected = w[EXP_MSB -: FIELD_W];
        f.mode     = w[MODE_BIT];
        return f;
    endfunction

endpackage

// File: rtl/int_fp_add_pattern_checker_settle_timer.sv
// Loadable down-counter with a zero flag; sets the wait between applying
// operands to the adder and sampling its result.
module int_fp_settle_timer
    import int_fp_mac_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/int_fp_add_pattern_checker.sv
// Golden-pattern checker for an external int_fp_add: fetches vectors, applies
// them, compares after a settle time and keeps saturating statistics.
// Optional macro INT_FP_CHECK_FAIL_STOP_EN ends the run at the first mismatch.
module int_fp_add_pattern_checker
    import int_fp_mac_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8,
    parameter int VEC_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [PAT_W-1:0]   pat_data,
    input  logic               pat_last,
    output logic               dut_mode,
    output logic [FIELD_W-1:0] dut_in1,
    output logic [FIELD_W-1:0] dut_in2,
    input  logic [FIELD_W-1:0] dut_result,
    output logic               pass_pulse,
    output logic               fail_pulse,
    output logic [ERR_W-1:0]   error_cnt,
    output logic [VEC_W-1:0]   vec_cnt,
    output logic               busy,
    output logic               done
);

`ifdef INT_FP_CHECK_FAIL_STOP_EN
    localparam bit FAIL_STOP = 1'b1;
`else
    localparam bit FAIL_STOP = 1'b0;
`endif

    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic [VEC_W-1:0] sat_inc_vec(input logic [VEC_W-1:0] v);
        return (v == '1) ? v : v + VEC_W'(1);
    endfunction

    chk_state_e   state_q, state_d;
    pat_fields_t  pat_q, pat_d;
    logic         last_q, last_d;
    logic         pass_pulse_q, pass_pulse_d;
    logic         fail_pulse_q, fail_pulse_d;
    logic [ERR_W-1:0] error_cnt_q, error_cnt_d;
    logic [VEC_W-1:0] vec_cnt_q, vec_cnt_d;

    logic accept;
    logic in_check;
    logic restart;
    logic timer_dec;
    logic timer_zero;
    logic mismatch;

    assign mismatch = (dut_result != pat_q.expected);

    int_fp_settle_timer u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (pat_valid) state_d = ST_APPLY;
            ST_APPLY: if (timer_zero) state_d = ST_CHECK;
            ST_CHECK: begin
                if (last_q || (FAIL_STOP && mismatch)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE:  if (start) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pat_ready = (state_q == ST_FETCH);
        busy      = (state_q == ST_FETCH) || (state_q == ST_APPLY) || (state_q == ST_CHECK);
        done      = (state_q == ST_DONE);
        accept    = pat_ready && pat_valid;
        timer_dec = (state_q == ST_APPLY);
        in_check  = (state_q == ST_CHECK);
        restart   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // Pattern fields are captured only on the handshake, so the adder
    // operands stay frozen through APPLY and CHECK.
    always_comb begin
        pat_d        = pat_q;
        last_d       = last_q;
        pass_pulse_d = in_check && !mismatch;
        fail_pulse_d = in_check && mismatch;
        error_cnt_d  = error_cnt_q;
        vec_cnt_d    = vec_cnt_q;
        if (accept) begin
            pat_d  = unpack_pat(pat_data);
            last_d = pat_last;
        end
        if (restart) begin
            error_cnt_d = '0;
            vec_cnt_d   = '0;
        end else if (in_check) begin
            vec_cnt_d = sat_inc_vec(vec_cnt_q);
            if (mismatch) begin
                error_cnt_d = sat_inc_err(error_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q        <= '0;
            last_q       <= 1'b0;
            pass_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
            error_cnt_q  <= '0;
            vec_cnt_q    <= '0;
        end else begin
            pat_q        <= pat_d;
            last_q       <= last_d;
            pass_pulse_q <= pass_pulse_d;
            fail_pulse_q <= fail_pulse_d;
            error_cnt_q  <= error_cnt_d;
            vec_cnt_q    <= vec_cnt_d;
        end
    end

    assign dut_mode   = pat_q.mode;
    assign dut_in1    = pat_q.in1;
    assign dut_in2    = pat_q.in2;
    assign pass_pulse = pass_pulse_q;
    assign fail_pulse = fail_pulse_q;
    assign error_cnt  = error_cnt_q;
    assign vec_cnt    = vec_cnt_q;

endmodule

// File: tb/tb_int_fp_add_pattern_checker.sv
// Scoreboard bench for int_fp_add_pattern_checker with a memoised stand-in
// adder; honours INT_FP_CHECK_FAIL_STOP_EN when defined.
module tb_int_fp_add_pattern_checker;

    localparam int SETTLE = 4;
    localparam int ERR_W  = 8;
    localparam int VEC_W  = 16;
`ifdef INT_FP_CHECK_FAIL_STOP_EN
    localparam bit FAIL_STOP = 1'b1;
`else
    localparam bit FAIL_STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pat_valid = 1'b0;
    logic        pat_ready;
    logic [48:0] pat_data = '0;
    logic        pat_last = 1'b0;
    logic        dut_mode;
    logic [15:0] dut_in1, dut_in2;
    logic [15:0] dut_result = 16'h0;
    logic        pass_pulse, fail_pulse;
    logic [ERR_W-1:0] error_cnt;
    logic [VEC_W-1:0] vec_cnt;
    logic        busy, done;

    int_fp_add_pattern_checker #(
        .SETTLE_CYCLES(SETTLE), .ERR_W(ERR_W), .VEC_W(VEC_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data), .pat_last(pat_last),
        .dut_mode(dut_mode), .dut_in1(dut_in1), .dut_in2(dut_in2), .dut_result(dut_result),
        .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .error_cnt(error_cnt), .vec_cnt(vec_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Stand-in adder: a deterministic function of its operands, memoised so a
    // repeated operand set always yields the same result.
    logic [15:0] adder_tbl [logic [16:0]];
    logic [16:0] adder_key;
    always @(dut_mode or dut_in1 or dut_in2) begin
        adder_key = {dut_mode, dut_in1, dut_in2};
        if (adder_tbl.exists(adder_key)) dut_result = adder_tbl[adder_key];
        else dut_result = 16'h0000;
    end

    typedef struct { bit pass; int vec; int err; int hs; } exp_t;
    typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] e; logic m; } vec_t;
    exp_t sb[$];
    vec_t vq[$];
    exp_t mon_x;
    int   ref_vec = 0;
    int   ref_err = 0;

    always @(negedge clk) begin
        if (reset && (pass_pulse || fail_pulse)) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_pulse", {pass_pulse, fail_pulse}, 0);
            end else begin
                mon_x = sb.pop_front();
                check(!(pass_pulse && fail_pulse), "pulse_exclusive", {pass_pulse, fail_pulse}, 0);
                check(pass_pulse == mon_x.pass, "pulse_kind", pass_pulse, mon_x.pass);
                check(int'(vec_cnt) == mon_x.vec, "vec_cnt", vec_cnt, mon_x.vec);
                check(int'(error_cnt) == mon_x.err, "error_cnt", error_cnt, mon_x.err);
                check(cyc - mon_x.hs == SETTLE + 1, "latency", cyc - mon_x.hs, SETTLE + 1);
            end
        end
    end

    task automatic add_raw(input logic [15:0] a, input logic [15:0] b, input logic m, input logic [15:0] e);
        vq.push_back('{a, b, e, m});
    endtask

    task automatic add_rand(input bit match);
        logic [15:0] a, b, r, e;
        logic        m;
        a = 16'($urandom);
        b = 16'($urandom);
        m = 1'($urandom_range(1, 0));
        if (!adder_tbl.exists({m, a, b})) adder_tbl[{m, a, b}] = 16'($urandom);
        r = adder_tbl[{m, a, b}];
        e = match ? r : (r ^ 16'($urandom_range(65535, 1)));
        add_raw(a, b, m, e);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pat_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(1'b0, "ready_timeout", 0, 1);
    endtask

    // Entered at a negedge with pat_ready high; returns 1ns after the handshake edge.
    task automatic drive_vec(input vec_t v, input bit last, input bit push);
        logic [15:0] r;
        pat_valid = 1'b1;
        pat_data  = {v.a, v.b, v.e, v.m};
        pat_last  = last;
        if (push) begin
            r = adder_tbl[{v.m, v.a, v.b}];
            ref_vec++;
            if (r != v.e) ref_err++;
            sb.push_back('{r == v.e, sat(ref_vec, VEC_W), sat(ref_err, ERR_W), cyc + 1});
        end
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        pat_last  = 1'b0;
        pat_data  = {17'($urandom), 32'($urandom)};
    endtask

    task automatic begin_run;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ref_vec = 0;
        ref_err = 0;
        check(busy && !done, "start_busy", {busy, done}, 2'b10);
        check(vec_cnt == '0 && error_cnt == '0, "start_clears", {vec_cnt, error_cnt}, 0);
    endtask

    task automatic run_queue(input int start_mid_at);
        bit ok, pass_v, got_done;
        int n;
        n = vq.size();
        for (int i = 0; i < n; i++) begin
            wait_ready(ok);
            if (!ok) break;
            pass_v = (adder_tbl[{vq[i].m, vq[i].a, vq[i].b}] == vq[i].e);
            drive_vec(vq[i], i == n - 1, 1'b1);
            if (i == start_mid_at) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check(busy && !pat_ready && int'(vec_cnt) == ref_vec - 1, "start_ignored_busy",
                      vec_cnt, ref_vec - 1);
            end
            if (i == n - 1 || (FAIL_STOP && !pass_v)) break;
        end
        got_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check(got_done, "done_timeout", got_done, 1);
        @(negedge clk);
        check(done && !busy, "done_held", {done, busy}, 2'b10);
        check(int'(vec_cnt) == sat(ref_vec, VEC_W), "final_vec_cnt", vec_cnt, sat(ref_vec, VEC_W));
        check(int'(error_cnt) == sat(ref_err, ERR_W), "final_error_cnt", error_cnt, sat(ref_err, ERR_W));
        check(sb.size() == 0, "sb_drained", sb.size(), 0);
        vq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [32:0] snap;

        adder_tbl[{1'b1, 16'h3C00, 16'h3C00}] = 16'h4000;
        adder_tbl[{1'b0, 16'h1111, 16'h2222}] = 16'h3333;
        adder_tbl[{1'b1, 16'h4242, 16'h0101}] = 16'h3C00;
        adder_tbl[{1'b0, 16'h0F0F, 16'hF0F0}] = 16'hFFFF;

        repeat (3) @(negedge clk);
        check({pat_ready, busy, done, pass_pulse, fail_pulse} == 5'b0, "reset_ctrl",
              {pat_ready, busy, done, pass_pulse, fail_pulse}, 0);
        check(error_cnt == '0 && vec_cnt == '0, "reset_cnt", {error_cnt, vec_cnt}, 0);
        check({dut_mode, dut_in1, dut_in2} == 33'b0, "reset_dut", {dut_mode, dut_in1, dut_in2}, 0);
        reset = 1'b1;

        @(negedge clk);
        pat_valid = 1'b1;
        pat_data  = {17'h1ABCD, 32'h12345678};
        repeat (3) @(negedge clk);
        check(!busy && !pat_ready && dut_in1 == 16'h0 && dut_in2 == 16'h0, "idle_ignores_valid",
              {busy, pat_ready, dut_in1}, 0);
        pat_valid = 1'b0;

        begin_run;
        add_raw(16'h3C00, 16'h3C00, 1'b1, 16'h4000);
        run_queue(-1);
        check({dut_mode, dut_in1, dut_in2} == {1'b1, 16'h3C00, 16'h3C00}, "dut_hold",
              {dut_mode, dut_in1, dut_in2}, {1'b1, 16'h3C00, 16'h3C00});

        begin_run;
        add_raw(16'h1111, 16'h2222, 1'b0, 16'h3333);
        add_raw(16'h4242, 16'h0101, 1'b1, 16'h4000);
        add_raw(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF);
        run_queue(1);
        check(error_cnt == 8'd1 && vec_cnt == (FAIL_STOP ? 16'd2 : 16'd3), "three_vec_counts",
              {error_cnt, vec_cnt}, {8'd1, (FAIL_STOP ? 16'd2 : 16'd3)});

        begin_run;
        wait_ready(ok);
        snap = {dut_mode, dut_in1, dut_in2};
        for (int i = 0; i < 10; i++) begin
            pat_data = {17'($urandom), 32'($urandom)};
            @(negedge clk);
            check(pat_ready && busy && !pass_pulse && !fail_pulse && {dut_mode, dut_in1, dut_in2} == snap,
                  "fetch_stall", {pat_ready, busy, dut_in1}, {2'b11, snap[31:16]});
        end
        add_rand(1'b1);
        add_rand(1'b1);
        run_queue(-1);

        begin_run;
        for (int i = 0; i < 20; i++) add_rand(bit'($urandom_range(1, 0)));
        run_queue(-1);

        begin_run;
        for (int i = 0; i < 300; i++) add_rand(1'b0);
        run_queue(-1);
        check(error_cnt == (FAIL_STOP ? 8'd1 : 8'd255), "err_saturate", error_cnt,
              (FAIL_STOP ? 8'd1 : 8'd255));

        begin_run;
        add_rand(1'b1);
        add_rand(1'b0);
        add_rand(1'b1);
        add_rand(1'b1);
        add_rand(1'b1);
        run_queue(-1);
        check(vec_cnt == (FAIL_STOP ? 16'd2 : 16'd5), "failstop_vec", vec_cnt, (FAIL_STOP ? 16'd2 : 16'd5));
        check(error_cnt == 8'd1, "failstop_err", error_cnt, 1);

        begin_run;
        add_rand(1'b1);
        wait_ready(ok);
        drive_vec(vq[0], 1'b0, 1'b0);
        vq.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check({pat_ready, busy, done, pass_pulse, fail_pulse} == 5'b0, "midrun_reset_ctrl",
              {pat_ready, busy, done, pass_pulse, fail_pulse}, 0);
        check({dut_mode, dut_in1, dut_in2, error_cnt, vec_cnt} == '0, "midrun_reset_data",
              {dut_mode, dut_in1, dut_in2}, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check(!busy && !pat_ready && !done, "idle_after_reset", {busy, pat_ready, done}, 0);

        begin_run;
        add_rand(1'b1);
        run_queue(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_fp_add_pattern_checker.md
Name: int_fp_add_pattern_checker

Overview:
- Synthesizable on-chip pattern consumer and checker for the int_fp_add datapath.
- Accepts golden-pattern words {input1, input2, expected, mode} over a valid/ready stream and drives the operands to an external int_fp_add instance.
- Waits a fixed settle time, compares the result with the expected value, and keeps pass/error statistics.
- Sits between the pattern source (ROM, host stream or testbench driver) and the adder under test. Used for silicon/FPGA BIST and for regression.

Parameters:
- SETTLE_CYCLES, 4, clocks from operand update to result sampling; legal range 1..255.
- ERR_W, 8, width of the error counter (saturating).
- VEC_W, 16, width of the vector counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a run; clears the counters.
- pat_valid  in  1  pattern word valid.
- pat_ready  out  1  checker can accept a pattern word.
- pat_data  in  49  {input1[48:33], input2[32:17], expected[16:1], mode[0]}.
- pat_last  in  1  qualifies the final pattern word of a run.
- dut_mode  out  1  mode bit to the adder.
- dut_in1  out  16  operand 1 to the adder.
- dut_in2  out  16  operand 2 to the adder.
- dut_result  in  16  adder result.
- pass_pulse  out  1  one-cycle pulse: vector matched.
- fail_pulse  out  1  one-cycle pulse: vector mismatched.
- error_cnt  out  ERR_W  mismatches in the current run.
- vec_cnt  out  VEC_W  vectors checked in the current run.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.

Behaviour:
- Reset values (asynchronous, reset=0): state IDLE; all outputs 0; pattern registers 0.
- States: IDLE, FETCH, APPLY, CHECK, DONE. busy=1 in FETCH, APPLY and CHECK.
- IDLE: start=1 -> FETCH; error_cnt and vec_cnt cleared on the same edge.
- DONE: done=1. start=1 -> FETCH, with counters cleared and done dropped on the same edge.
- start is ignored while busy.
- FETCH:
  - pat_ready=1 only in this state.
  - On pat_valid && pat_ready: register the four fields and pat_last. dut_* outputs take the new values on that edge. Load the settle counter with SETTLE_CYCLES-1 and go to APPLY.
  - No handshake -> remain in FETCH; dut_* hold their previous values.
- APPLY: decrement the settle counter; when it reaches 0 -> CHECK. Total operand-to-sample latency is SETTLE_CYCLES+1 clocks from the accepting edge (default 5).
- CHECK:
  - Compare dut_result with the registered expected value, full 16-bit equality; no NaN special-casing.
  - Equal -> pass_pulse=1 for one cycle. Unequal -> fail_pulse=1 for one cycle and error_cnt+1.
  - vec_cnt+1 in both cases.
  - Both counters saturate at all-ones and never wrap.
  - Next state: DONE if the registered last flag is set, else FETCH.
- dut_* outputs are registered and stable from the accepting edge through CHECK.
- pass_pulse and fail_pulse are never asserted together.
- pat_data is sampled only on the handshake edge. pat_valid without ready is allowed and must not alter state.
- Reset mid-run: immediate return to IDLE; counters cleared; any pending vector is discarded.

Optional Feature:
- Macro: INT_FP_CHECK_FAIL_STOP_EN.
- Defined: the first mismatch ends the run. CHECK goes to DONE regardless of the last flag, error_cnt=1, and vec_cnt holds the failing vector's 1-based index.
- Not defined: all vectors run to pat_last (behaviour above).

Decomposition:
- Shared package int_fp_mac_pkg:
  - PAT_W=49 and the field offset/width constants (IN1_MSB, IN2_MSB, EXP_MSB, MODE_BIT).
  - Checker state encoding as a typedef/localparam set.
- One sub-module is natural: int_fp_settle_timer, a loadable down-counter with a zero flag.
- The adder itself stays external and is connected by the integrator.

Test Plan:
- Reset, then start, then one word {3C00,3C00,4000,1} with pat_last=1; adder model returns 4000 -> one pass_pulse 5 clocks after the handshake, vec_cnt=1, error_cnt=0, done=1.
- Three words, the second expecting 4000 while the model returns 3C00 -> exactly one fail_pulse, error_cnt=1, vec_cnt=3, done after the third CHECK.
- Hold pat_valid low for 10 cycles in FETCH -> pat_ready stays 1, busy=1, no pulses, dut_* unchanged.
- Assert start while busy, then again in DONE -> first ignored; second clears counters and restarts fetch on the next edge.
- 300 mismatching vectors -> error_cnt saturates at 255, vec_cnt=300.
- Drive reset=0 during APPLY -> all outputs 0 asynchronously; after release, state is IDLE awaiting start. With INT_FP_CHECK_FAIL_STOP_EN defined, a mismatch on vector 2 of 5 -> done, vec_cnt=2.
